// File: rtl/bank_mem_responder_pkg.sv
// Shared constants and address-decode helpers for the four-bank interleaved responder.
package bank_mem_responder_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned BANK_WORDS = 8192;
    localparam int unsigned BANK_CYC   = 4;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned BANK_SEL_W = $clog2(NUM_BANKS);
    localparam int unsigned IDX_W      = $clog2(BANK_WORDS);
    localparam int unsigned CNT_W      = $clog2(BANK_CYC);

    function automatic logic [BANK_SEL_W-1:0] bank_sel(input logic [ADDR_W-1:0] a);
        return a[BANK_SEL_W:1];
    endfunction

    function automatic logic [IDX_W-1:0] bank_idx(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:BANK_SEL_W+1];
    endfunction

endpackage

// File: rtl/bank_mem_responder_mem_bank.sv
// One interleaved bank: storage, occupancy counter and registered read port.
module mem_bank
    import bank_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_acc,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_rd_vld,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [BANK_WORDS];
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_busy;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rdata;

    // Accept reloads the occupancy window; otherwise count down and hold at zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_acc) begin
            w_cnt_nxt = CNT_W'(BANK_CYC - 1);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_busy   <= (w_cnt_nxt != '0);
            r_rd_vld <= i_acc & ~i_we;
        end
    end

    // Array contents survive reset; read data is qualified by r_rd_vld.
    always_ff @(posedge clk) begin
        if (i_acc & i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_acc & ~i_we) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_busy   = r_busy;
    assign o_rd_vld = r_rd_vld;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/bank_mem_responder.sv
// Four-bank word-interleaved memory responder: request decode, bank stall and read return stage.
module bank_mem_responder
    import bank_mem_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 rd,
    input  logic                 wr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    logic                  w_req;
    logic                  w_illegal;
    logic                  w_accept;
    logic [BANK_SEL_W-1:0] w_bank;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_BANKS-1:0]  w_acc;
    logic [NUM_BANKS-1:0]  w_busy;
    logic [NUM_BANKS-1:0]  w_rd_vld;
    logic [DATA_W-1:0]     w_rdata [NUM_BANKS];
    logic [DATA_W-1:0]     w_mux;
    logic                  r_err;

    assign w_req     = rd ^ wr;
    assign w_bank    = bank_sel(addr);
    assign w_idx     = bank_idx(addr);
    assign w_illegal = (rd & wr) | (w_req & addr[0]);
    assign stall     = w_req & ~addr[0] & w_busy[w_bank];
    assign w_accept  = w_req & ~addr[0] & ~w_busy[w_bank];
    assign busy      = w_busy;
    assign err       = r_err;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign w_acc[g] = w_accept && (w_bank == BANK_SEL_W'(g));

        mem_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_acc    (w_acc[g]),
            .i_we     (wr),
            .i_idx    (w_idx),
            .i_wdata  (data_in),
            .o_busy   (w_busy[g]),
            .o_rd_vld (w_rd_vld[g]),
            .o_rdata  (w_rdata[g])
        );
    end

    // At most one bank issues a read per cycle, so an OR of gated words is a clean mux.
    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (w_rd_vld[i]) begin
                w_mux = w_mux | w_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_illegal;
        end
    end

    if (RD_LAT > 1) begin : g_out_reg
        logic              r_data_valid;
        logic [DATA_W-1:0] r_data_out;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_valid <= 1'b0;
                r_data_out   <= '0;
            end else begin
                r_data_valid <= |w_rd_vld;
                r_data_out   <= w_mux;
            end
        end

        assign data_valid = r_data_valid;
        assign data_out   = r_data_out;
    end else begin : g_out_comb
        assign data_valid = |w_rd_vld;
        assign data_out   = w_mux;
    end

endmodule
